// File: rtl/contador_palabras_if.sv
// Query/pop bundle between the switch output side and the word counter.
`timescale 1ns/1ps
interface contador_palabras_if #(
    parameter int CNT_WIDTH = 5,
    parameter int IDX_WIDTH = 2
);
    logic                 pop4;
    logic                 pop5;
    logic                 pop6;
    logic                 pop7;
    logic                 empty4;
    logic                 empty5;
    logic                 empty6;
    logic                 empty7;
    logic                 IDLE;
    logic                 req;
    logic [IDX_WIDTH-1:0] idx;
    logic                 valid_contador;
    logic [CNT_WIDTH-1:0] contador_out;

    modport master (
        output pop4, pop5, pop6, pop7,
        output empty4, empty5, empty6, empty7,
        output IDLE, req, idx,
        input  valid_contador, contador_out
    );

    modport slave (
        input  pop4, pop5, pop6, pop7,
        input  empty4, empty5, empty6, empty7,
        input  IDLE, req, idx,
        output valid_contador, contador_out
    );
endinterface

// File: rtl/contador_palabras.sv
// Per-output-FIFO popped-word counters with a registered, non-destructive read port.
// Response 1 cycle after req; no backpressure, queries answered only while IDLE is high.
`timescale 1ns/1ps
module contador_palabras #(
    parameter int CNT_WIDTH = 5,
    parameter int IDX_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    contador_palabras_if.slave    bus
);
    typedef enum logic [1:0] {
        S_BLOCK = 2'd0,
        S_READY = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q [4];
    logic [CNT_WIDTH-1:0] cnt_d [4];
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] out_q, out_d;
    logic [3:0]           pop_acc;
    logic [IDX_WIDTH-1:0] idx_sel;

    // A pop only moves a word when the FIFO actually holds one.
    assign pop_acc = {bus.pop7 & ~bus.empty7,
                      bus.pop6 & ~bus.empty6,
                      bus.pop5 & ~bus.empty5,
                      bus.pop4 & ~bus.empty4};
    assign idx_sel = bus.idx;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            cnt_d[n] = cnt_q[n] + CNT_WIDTH'(pop_acc[n]);
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        out_d   = '0;
        if (!bus.IDLE) begin
            state_d = S_BLOCK;
        end else begin
            case (state_q)
                S_BLOCK: state_d = S_READY;
                S_READY, S_RESP: begin
                    if (bus.req) begin
                        state_d = S_RESP;
                        valid_d = 1'b1;
                        out_d   = cnt_q[idx_sel];
                    end else begin
                        state_d = S_READY;
                    end
                end
                default: state_d = S_BLOCK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BLOCK;
            valid_q <= 1'b0;
            out_q   <= '0;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign bus.valid_contador = valid_q;
    assign bus.contador_out   = out_q;
endmodule

// File: tb/tb_contador_palabras.sv
// Bench for contador_palabras: directed vector table, wrap/reset sequences, randomized run against a rule model.
`timescale 1ns/1ps
module tb_contador_palabras;
    localparam int CW = 5;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    contador_palabras_if #(.CNT_WIDTH(CW), .IDX_WIDTH(IW)) bus ();
    contador_palabras #(.CNT_WIDTH(CW), .IDX_WIDTH(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic       idle;
        logic       rq;
        logic [1:0] ix;
        logic [3:0] pop;
        logic [3:0] emp;
        logic       ev;
        logic [4:0] eo;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Rule model: a response needs IDLE high on this edge and on the previous non-reset edge.
    int   m_cnt[4];
    bit   m_ready = 1'b0;
    bit   m_v     = 1'b0;
    int   m_o     = 0;

    function automatic vec_t mk(logic rst, logic idle, logic rq, logic [1:0] ix,
                                logic [3:0] pop, logic [3:0] emp, logic ev, logic [4:0] eo);
        vec_t v;
        v.rst = rst; v.idle = idle; v.rq = rq; v.ix = ix;
        v.pop = pop; v.emp = emp; v.ev = ev; v.eo = eo;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic idle, input logic rq, input logic [1:0] ix,
                         input logic [3:0] pop, input logic [3:0] emp);
        reset      = rst;
        bus.IDLE   = idle;
        bus.req    = rq;
        bus.idx    = ix;
        bus.pop4   = pop[0];
        bus.pop5   = pop[1];
        bus.pop6   = pop[2];
        bus.pop7   = pop[3];
        bus.empty4 = emp[0];
        bus.empty5 = emp[1];
        bus.empty6 = emp[2];
        bus.empty7 = emp[3];
        @(posedge clk);
        #1;
        if (rst) begin
            for (int n = 0; n < 4; n++) m_cnt[n] = 0;
            m_ready = 1'b0;
            m_v     = 1'b0;
            m_o     = 0;
        end else begin
            m_v = idle && rq && m_ready;
            m_o = m_v ? m_cnt[ix] : 0;
            for (int n = 0; n < 4; n++) begin
                if (pop[n] && !emp[n]) m_cnt[n] = (m_cnt[n] + 1) % 32;
            end
            m_ready = idle;
        end
    endtask

    task automatic check(input string name, input logic ev, input logic [4:0] eo);
        checks++;
        if (bus.valid_contador !== ev || bus.contador_out !== eo) begin
            errors++;
            $display("FAIL %s: got valid=%0b out=%0d, expected valid=%0b out=%0d",
                     name, bus.valid_contador, bus.contador_out, ev, eo);
        end
    endtask

    initial begin
        // Reset, zero reads, pops on FIFO4, ignored pops on empty FIFO5, IDLE gating, 16-word run.
        vecs.push_back(mk(1,0,0,0,4'h0,4'h0,0,0));
        vecs.push_back(mk(1,0,0,0,4'h0,4'h0,0,0));
        vecs.push_back(mk(0,1,1,0,4'h0,4'h0,0,0));
        vecs.push_back(mk(0,1,1,0,4'h0,4'h0,1,0));
        vecs.push_back(mk(0,1,1,1,4'h0,4'h0,1,0));
        vecs.push_back(mk(0,1,1,2,4'h0,4'h0,1,0));
        vecs.push_back(mk(0,1,1,3,4'h0,4'h0,1,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,0,0,4'h1,4'h0,0,0));
        vecs.push_back(mk(0,1,1,0,4'h0,4'h0,1,4));
        vecs.push_back(mk(0,1,1,1,4'h0,4'h0,1,0));
        vecs.push_back(mk(0,1,1,2,4'h0,4'h0,1,0));
        vecs.push_back(mk(0,1,1,3,4'h0,4'h0,1,0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,0,0,4'h2,4'h2,0,0));
        vecs.push_back(mk(0,1,1,1,4'h0,4'h0,1,0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,1,0,4'h0,4'h0,0,0));
        vecs.push_back(mk(0,1,1,0,4'h0,4'h0,0,0));
        vecs.push_back(mk(0,1,1,0,4'h0,4'h0,1,4));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,0,0,4'hF,4'h0,0,0));
        vecs.push_back(mk(0,1,1,0,4'h0,4'h0,1,8));
        vecs.push_back(mk(0,1,1,0,4'h0,4'h0,1,8));
        vecs.push_back(mk(0,1,1,1,4'h0,4'h0,1,4));
        vecs.push_back(mk(0,1,1,2,4'h0,4'h0,1,4));
        vecs.push_back(mk(0,1,1,3,4'h0,4'h0,1,4));
        vecs.push_back(mk(0,1,1,3,4'h0,4'h0,1,4));
        vecs.push_back(mk(0,1,1,2,4'h4,4'h0,1,4));
        vecs.push_back(mk(0,1,1,2,4'h0,4'h0,1,5));
        vecs.push_back(mk(0,1,0,0,4'h0,4'h0,0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].idle, vecs[i].rq, vecs[i].ix, vecs[i].pop, vecs[i].emp);
            check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eo);
        end

        // Wrap: 33 accepted pops on FIFO7 from zero leave it at 1.
        drive(1, 0, 0, 0, 4'h0, 4'h0);
        check("wrap_reset", 0, 0);
        for (int i = 0; i < 33; i++) drive(0, 1, 0, 0, 4'h8, 4'h0);
        drive(0, 1, 1, 3, 4'h0, 4'h0);
        check("wrap_read", 1, 1);

        // Reset in the middle of a back-to-back read stream.
        drive(0, 1, 1, 0, 4'h0, 4'h0);
        check("stream_idx0", 1, 0);
        drive(0, 1, 1, 3, 4'h0, 4'h0);
        check("stream_idx3", 1, 1);
        drive(1, 1, 1, 1, 4'h0, 4'h0);
        check("stream_reset", 0, 0);
        drive(0, 1, 1, 3, 4'h0, 4'h0);
        check("post_reset_block", 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 2'(i), 4'h0, 4'h0);
            check($sformatf("post_reset_idx%0d", i), 1, 0);
        end

        // Randomized traffic against the rule model.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            check($sformatf("rand%0d", i), m_v, 5'(m_o));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
